// File: rtl/bpd_upd_sched_pkg.sv
// Shared types and defaults for the predictor update scheduler.
// Retire entry layout helpers and PHT counter init values.
package bpd_upd_sched_pkg;

   localparam int GLOG_DEF  = 12;
   localparam int LLOG_DEF  = 10;
   localparam int DEPTH_DEF = 4;
   localparam int STARVE_DEF = 3;

   // PHT counter init values (weakly not-taken)
   localparam logic [1:0] SATCNTINIT2 = 2'b01;
   localparam logic [2:0] SATCNTINIT3 = 3'b011;

   typedef enum logic {
      S_INIT,
      S_RUN
   } state_t;

   // entry = {idx[GLOG], bhr[GLOG], lochist[LLOG], dir}
   function automatic int ent_w(int g, int l);
      return 2 * g + l + 1;
   endfunction

   function automatic int off_loch();
      return 1;
   endfunction

   function automatic int off_bhr(int l);
      return 1 + l;
   endfunction

   function automatic int off_idx(int g, int l);
      return 1 + l + g;
   endfunction

endpackage

// File: rtl/bpd_upd_fifo.sv
// Retire-outcome FIFO for the predictor update scheduler.
// Synchronous, DEPTH entries, full/empty flags.
module bpd_upd_fifo #(
   parameter int W     = 35,
   parameter int DEPTH = 4
) (
   input  logic         clock,
   input  logic         reset_n,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout,
   output logic         full,
   output logic         empty
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0] mem [DEPTH];
   logic [AW:0]  wr_ptr;
   logic [AW:0]  rd_ptr;

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                  (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign dout  = mem[rd_ptr[AW-1:0]];

   // pointer update; reset empties the queue
   always_ff @(posedge clock or posedge reset_n) begin
      if (reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // storage write, data needs no reset
   always_ff @(posedge clock) begin
      if (push)
         mem[wr_ptr[AW-1:0]] <= din;
   end

endmodule

// File: rtl/bpd_upd_sched.sv
// PHT port scheduler: init sweep, retire-update arbitration
// against fetch lookups, and BHR restore on flush.
module bpd_upd_sched
   import bpd_upd_sched_pkg::*;
#(
   parameter int GLOG       = GLOG_DEF,
   parameter int LLOG       = LLOG_DEF,
   parameter int DEPTH      = DEPTH_DEF,
   parameter int STARVE_MAX = STARVE_DEF
) (
   input  logic            clock,
   input  logic            reset_n,
   input  logic            ret_valid_i,
   output logic            ret_ready_o,
   input  logic [63:0]     ret_pc_i,
   input  logic [GLOG-1:0] ret_bhr_i,
   input  logic [LLOG-1:0] ret_lochist_i,
   input  logic            ret_brdir_i,
   input  logic            rd_req_i,
   output logic            rd_grant_o,
   output logic            upd_we_o,
   output logic            upd_init_o,
   output logic [GLOG-1:0] upd_gidx_o,
   output logic [LLOG-1:0] upd_lidx_o,
   output logic            upd_brdir_o,
   output logic            init_done_o,
   input  logic            flush_i,
   output logic            bhr_rst_valid_o,
   output logic [GLOG-1:0] bhr_rst_o
);

   localparam int EW = ent_w(GLOG, LLOG);
   localparam int OL = off_loch();
   localparam int OB = off_bhr(LLOG);
   localparam int OI = off_idx(GLOG, LLOG);
   localparam int SW = $clog2(STARVE_MAX + 1);
   localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);

   state_t          state;
   state_t          state_nxt;
   logic [GLOG-1:0] cnt;
   logic [SW-1:0]   starve;
   logic [GLOG-1:0] last_ret;
   logic [GLOG-1:0] new_ret;
   logic            full;
   logic            empty;
   logic            push;
   logic            pop;
   logic [EW-1:0]   din;
   logic [EW-1:0]   head;
   logic            unused_pc;

   assign unused_pc = ^{ret_pc_i[63:GLOG+2], ret_pc_i[1:0]};

   assign din = {ret_pc_i[GLOG+1:2], ret_bhr_i,
                 ret_lochist_i, ret_brdir_i};
   assign push = ret_valid_i & ret_ready_o;
   assign new_ret = {ret_bhr_i[GLOG-2:0], ret_brdir_i};

   bpd_upd_fifo #(
      .W     (EW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clock   (clock),
      .reset_n (reset_n),
      .push    (push),
      .pop     (pop),
      .din     (din),
      .dout    (head),
      .full    (full),
      .empty   (empty)
   );

   // port arbitration, write-side outputs and next state
   always_comb begin
      state_nxt   = state;
      pop         = 1'b0;
      ret_ready_o = 1'b0;
      rd_grant_o  = 1'b0;
      upd_we_o    = 1'b0;
      upd_init_o  = 1'b0;
      upd_gidx_o  = '0;
      upd_lidx_o  = '0;
      upd_brdir_o = 1'b0;
      if (!reset_n) begin
         ret_ready_o = !full;
         unique case (state)
            S_INIT: begin
               upd_we_o   = 1'b1;
               upd_init_o = 1'b1;
               upd_gidx_o = cnt;
               upd_lidx_o = cnt[LLOG-1:0];
               if (cnt == '1)
                  state_nxt = S_RUN;
            end
            S_RUN: begin
               pop = !empty &
                     (!rd_req_i | full | (starve == SMAX));
               rd_grant_o = rd_req_i & !pop;
               if (pop) begin
                  upd_we_o    = 1'b1;
                  upd_gidx_o  = head[OI +: GLOG] ^
                                head[OB +: GLOG];
                  upd_lidx_o  = head[OL +: LLOG];
                  upd_brdir_o = head[0];
               end
            end
            default: state_nxt = S_INIT;
         endcase
      end
   end

   // FSM, sweep counter, starve counter and restore registers
   always_ff @(posedge clock or posedge reset_n) begin
      if (reset_n) begin
         state           <= S_INIT;
         cnt             <= '0;
         init_done_o     <= 1'b0;
         starve          <= '0;
         last_ret        <= '0;
         bhr_rst_valid_o <= 1'b0;
         bhr_rst_o       <= '0;
      end else begin
         state <= state_nxt;
         if (state == S_INIT) begin
            cnt <= cnt + 1'b1;
            if (cnt == '1)
               init_done_o <= 1'b1;
         end
         if (state != S_RUN || empty || pop)
            starve <= '0;
         else if (starve != SMAX)
            starve <= starve + 1'b1;
         if (push)
            last_ret <= new_ret;
         bhr_rst_valid_o <= flush_i;
         if (flush_i)
            bhr_rst_o <= push ? new_ret : last_ret;
      end
   end

endmodule

// File: tb/tb_bpd_upd_sched.sv
// Directed bench for bpd_upd_sched.
// Each task drives one scenario and checks inline.
module tb_bpd_upd_sched;

   logic        clock;
   logic        reset_n;
   logic        ret_valid_i;
   logic        ret_ready_o;
   logic [63:0] ret_pc_i;
   logic [11:0] ret_bhr_i;
   logic [9:0]  ret_lochist_i;
   logic        ret_brdir_i;
   logic        rd_req_i;
   logic        rd_grant_o;
   logic        upd_we_o;
   logic        upd_init_o;
   logic [11:0] upd_gidx_o;
   logic [9:0]  upd_lidx_o;
   logic        upd_brdir_o;
   logic        init_done_o;
   logic        flush_i;
   logic        bhr_rst_valid_o;
   logic [11:0] bhr_rst_o;

   int vectors = 0;
   int miscompares = 0;

   logic [63:0] t_pc   [4];
   logic [11:0] t_bhr  [4];
   logic [9:0]  t_loch [4];
   logic        t_dir  [4];
   logic [11:0] t_gidx [4];

   bpd_upd_sched #(
      .GLOG       (12),
      .LLOG       (10),
      .DEPTH      (4),
      .STARVE_MAX (3)
   ) dut (
      .clock           (clock),
      .reset_n         (reset_n),
      .ret_valid_i     (ret_valid_i),
      .ret_ready_o     (ret_ready_o),
      .ret_pc_i        (ret_pc_i),
      .ret_bhr_i       (ret_bhr_i),
      .ret_lochist_i   (ret_lochist_i),
      .ret_brdir_i     (ret_brdir_i),
      .rd_req_i        (rd_req_i),
      .rd_grant_o      (rd_grant_o),
      .upd_we_o        (upd_we_o),
      .upd_init_o      (upd_init_o),
      .upd_gidx_o      (upd_gidx_o),
      .upd_lidx_o      (upd_lidx_o),
      .upd_brdir_o     (upd_brdir_o),
      .init_done_o     (init_done_o),
      .flush_i         (flush_i),
      .bhr_rst_valid_o (bhr_rst_valid_o),
      .bhr_rst_o       (bhr_rst_o)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic set_ret(input logic v, input logic [63:0] pc,
                          input logic [11:0] bhr,
                          input logic [9:0] loch, input logic dir);
      ret_valid_i   = v;
      ret_pc_i      = pc;
      ret_bhr_i     = bhr;
      ret_lochist_i = loch;
      ret_brdir_i   = dir;
   endtask

   task automatic test_reset();
      reset_n = 1'b1;
      flush_i = 1'b0;
      rd_req_i = 1'b1;
      set_ret(1'b1, 64'h4, 12'h1, 10'h1, 1'b1);
      tick();
      tick();
      #1;
      vectors++;
      if (upd_we_o !== 1'b0 || upd_init_o !== 1'b0 ||
          ret_ready_o !== 1'b0 || rd_grant_o !== 1'b0 ||
          init_done_o !== 1'b0 || bhr_rst_valid_o !== 1'b0 ||
          bhr_rst_o !== 12'h0 || upd_gidx_o !== 12'h0) begin
         miscompares++;
         $display("FAIL reset: we=%b init=%b rdy=%b gnt=%b done=%b rv=%b rst=%h gidx=%h, want all 0",
                  upd_we_o, upd_init_o, ret_ready_o, rd_grant_o,
                  init_done_o, bhr_rst_valid_o, bhr_rst_o, upd_gidx_o);
      end
      set_ret(1'b0, 64'h0, 12'h0, 10'h0, 1'b0);
   endtask

   task automatic test_init_sweep(input bit with_push);
      tick();
      reset_n = 1'b0;
      rd_req_i = 1'b1;
      for (int i = 0; i < 4096; i++) begin
         if (i != 0)
            tick();
         if (with_push && i < 4)
            set_ret(1'b1, t_pc[i], t_bhr[i], t_loch[i], t_dir[i]);
         else
            set_ret(1'b0, 64'h0, 12'h0, 10'h0, 1'b0);
         #1;
         vectors++;
         if (upd_we_o !== 1'b1 || upd_init_o !== 1'b1 ||
             upd_gidx_o !== 12'(i) || upd_lidx_o !== 10'(i) ||
             rd_grant_o !== 1'b0 || init_done_o !== 1'b0) begin
            miscompares++;
            $display("FAIL init_sweep i=%0d: we=%b init=%b gidx=%h lidx=%h gnt=%b done=%b, want 1 1 %h %h 0 0",
                     i, upd_we_o, upd_init_o, upd_gidx_o, upd_lidx_o,
                     rd_grant_o, init_done_o, 12'(i), 10'(i));
         end
         if (with_push && i <= 4) begin
            vectors++;
            if (ret_ready_o !== (i < 4)) begin
               miscompares++;
               $display("FAIL init_ready i=%0d: got %b want %b",
                        i, ret_ready_o, (i < 4));
            end
         end
      end
   endtask

   task automatic test_in_order_drain();
      for (int k = 0; k < 4; k++) begin
         tick();
         rd_req_i = 1'b0;
         #1;
         if (k == 0) begin
            vectors++;
            if (init_done_o !== 1'b1) begin
               miscompares++;
               $display("FAIL init_done: got %b want 1", init_done_o);
            end
         end
         vectors++;
         if (upd_we_o !== 1'b1 || upd_init_o !== 1'b0 ||
             upd_gidx_o !== t_gidx[k] || upd_lidx_o !== t_loch[k] ||
             upd_brdir_o !== t_dir[k]) begin
            miscompares++;
            $display("FAIL drain k=%0d: we=%b init=%b gidx=%h lidx=%h dir=%b, want 1 0 %h %h %b",
                     k, upd_we_o, upd_init_o, upd_gidx_o, upd_lidx_o,
                     upd_brdir_o, t_gidx[k], t_loch[k], t_dir[k]);
         end
      end
      tick();
      #1;
      vectors++;
      if (upd_we_o !== 1'b0 || ret_ready_o !== 1'b1) begin
         miscompares++;
         $display("FAIL drain_empty: we=%b rdy=%b, want 0 1",
                  upd_we_o, ret_ready_o);
      end
   endtask

   task automatic test_single_write();
      tick();
      rd_req_i = 1'b0;
      set_ret(1'b1, 64'h1000_0040, 12'h0A5, 10'h123, 1'b1);
      #1;
      vectors++;
      if (upd_we_o !== 1'b0) begin
         miscompares++;
         $display("FAIL same_cycle_write: we=%b want 0", upd_we_o);
      end
      tick();
      set_ret(1'b0, 64'h0, 12'h0, 10'h0, 1'b0);
      #1;
      vectors++;
      if (upd_we_o !== 1'b1 || upd_init_o !== 1'b0 ||
          upd_gidx_o !== 12'h0B5 || upd_lidx_o !== 10'h123 ||
          upd_brdir_o !== 1'b1) begin
         miscompares++;
         $display("FAIL single_write: we=%b init=%b gidx=%h lidx=%h dir=%b, want 1 0 0b5 123 1",
                  upd_we_o, upd_init_o, upd_gidx_o, upd_lidx_o,
                  upd_brdir_o);
      end
      tick();
      #1;
      vectors++;
      if (upd_we_o !== 1'b0) begin
         miscompares++;
         $display("FAIL single_after: we=%b want 0", upd_we_o);
      end
   endtask

   task automatic test_starve();
      tick();
      rd_req_i = 1'b1;
      set_ret(1'b1, 64'h8, 12'h0, 10'h0, 1'b0);
      #1;
      vectors++;
      if (rd_grant_o !== 1'b1 || upd_we_o !== 1'b0) begin
         miscompares++;
         $display("FAIL starve_push: gnt=%b we=%b, want 1 0",
                  rd_grant_o, upd_we_o);
      end
      for (int c = 0; c < 3; c++) begin
         tick();
         set_ret(1'b0, 64'h0, 12'h0, 10'h0, 1'b0);
         #1;
         vectors++;
         if (rd_grant_o !== 1'b1 || upd_we_o !== 1'b0) begin
            miscompares++;
            $display("FAIL starve_yield c=%0d: gnt=%b we=%b, want 1 0",
                     c, rd_grant_o, upd_we_o);
         end
      end
      tick();
      #1;
      vectors++;
      if (rd_grant_o !== 1'b0 || upd_we_o !== 1'b1 ||
          upd_gidx_o !== 12'h002) begin
         miscompares++;
         $display("FAIL starve_force: gnt=%b we=%b gidx=%h, want 0 1 002",
                  rd_grant_o, upd_we_o, upd_gidx_o);
      end
      tick();
      #1;
      vectors++;
      if (rd_grant_o !== 1'b1 || upd_we_o !== 1'b0) begin
         miscompares++;
         $display("FAIL starve_after: gnt=%b we=%b, want 1 0",
                  rd_grant_o, upd_we_o);
      end
      rd_req_i = 1'b0;
   endtask

   task automatic test_flush();
      tick();
      rd_req_i = 1'b0;
      set_ret(1'b1, 64'h0, 12'h7FF, 10'h0, 1'b0);
      #1;
      tick();
      set_ret(1'b0, 64'h0, 12'h0, 10'h0, 1'b0);
      flush_i = 1'b1;
      #1;
      vectors++;
      if (bhr_rst_valid_o !== 1'b0) begin
         miscompares++;
         $display("FAIL flush_early: rv=%b want 0", bhr_rst_valid_o);
      end
      tick();
      set_ret(1'b1, 64'h0, 12'h123, 10'h0, 1'b1);
      #1;
      vectors++;
      if (bhr_rst_valid_o !== 1'b1 || bhr_rst_o !== 12'hFFE) begin
         miscompares++;
         $display("FAIL flush_restore: rv=%b rst=%h, want 1 ffe",
                  bhr_rst_valid_o, bhr_rst_o);
      end
      tick();
      flush_i = 1'b0;
      set_ret(1'b0, 64'h0, 12'h0, 10'h0, 1'b0);
      #1;
      vectors++;
      if (bhr_rst_valid_o !== 1'b1 || bhr_rst_o !== 12'h247) begin
         miscompares++;
         $display("FAIL flush_b2b_push: rv=%b rst=%h, want 1 247",
                  bhr_rst_valid_o, bhr_rst_o);
      end
      tick();
      #1;
      vectors++;
      if (bhr_rst_valid_o !== 1'b0) begin
         miscompares++;
         $display("FAIL flush_end: rv=%b want 0", bhr_rst_valid_o);
      end
      tick();
      tick();
   endtask

   task automatic test_reset_mid_drain();
      rd_req_i = 1'b1;
      for (int p = 0; p < 3; p++) begin
         tick();
         set_ret(1'b1, 64'h10 + 64'(4 * p), 12'h0, 10'h0, 1'b0);
      end
      tick();
      set_ret(1'b0, 64'h0, 12'h0, 10'h0, 1'b0);
      rd_req_i = 1'b0;
      #1;
      vectors++;
      if (upd_we_o !== 1'b1 || upd_gidx_o !== 12'h004) begin
         miscompares++;
         $display("FAIL mid_drain0: we=%b gidx=%h, want 1 004",
                  upd_we_o, upd_gidx_o);
      end
      tick();
      #1;
      vectors++;
      if (upd_we_o !== 1'b1 || upd_gidx_o !== 12'h005) begin
         miscompares++;
         $display("FAIL mid_drain1: we=%b gidx=%h, want 1 005",
                  upd_we_o, upd_gidx_o);
      end
      reset_n = 1'b1;
      #1;
      vectors++;
      if (upd_we_o !== 1'b0 || init_done_o !== 1'b0) begin
         miscompares++;
         $display("FAIL mid_reset: we=%b done=%b, want 0 0",
                  upd_we_o, init_done_o);
      end
      tick();
      test_init_sweep(1'b0);
      tick();
      #1;
      vectors++;
      if (init_done_o !== 1'b1 || upd_we_o !== 1'b0) begin
         miscompares++;
         $display("FAIL fifo_cleared: done=%b we=%b, want 1 0",
                  init_done_o, upd_we_o);
      end
   endtask

   initial begin
      t_pc[0] = 64'h0000_0000_0000_0004;
      t_pc[1] = 64'h0000_0000_0000_0FFC;
      t_pc[2] = 64'hFFFF_0000_0000_4008;
      t_pc[3] = 64'h0000_0000_0000_3FF0;
      t_bhr[0] = 12'h001;
      t_bhr[1] = 12'hABC;
      t_bhr[2] = 12'h000;
      t_bhr[3] = 12'hFFF;
      t_loch[0] = 10'h3FF;
      t_loch[1] = 10'h001;
      t_loch[2] = 10'h155;
      t_loch[3] = 10'h000;
      t_dir[0] = 1'b1;
      t_dir[1] = 1'b0;
      t_dir[2] = 1'b1;
      t_dir[3] = 1'b0;
      t_gidx[0] = 12'h000;
      t_gidx[1] = 12'h943;
      t_gidx[2] = 12'h002;
      t_gidx[3] = 12'h003;

      test_reset();
      test_init_sweep(1'b1);
      test_in_order_drain();
      test_single_write();
      test_starve();
      test_flush();
      test_reset_mid_drain();

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
